mem_lsu: RTL and testbench

Load/store unit for the MEM pipeline stage: the initiator side of the word-only data memory port (`we`, `a`, `wd`, `rd`; asynchronous read, write on rising `clk`). It accepts byte, halfword and word load/store requests from the pipeline. It extracts and sign- or zero-extends sub-word load data. Sub-word stores are performed as a two-cycle read-modify-write, with the pipeline stalled through `req_ready`.

---
 rtl/mem_lsu_pkg.sv | 40 ++++
 rtl/mem_lsu_if.sv | 35 +++
 rtl/mem_lsu_lane_align.sv | 58 +++++
 rtl/mem_lsu.sv | 118 +++++++++++
 tb/tb_mem_lsu.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: shared types and constants for the MEM-stage load/store unit.
//   size_e      - access size (byte/half/word; raw 2'b11 decodes to word)
//   lsu_state_e - FSM states (idle, read-modify-write)
//   lane widths and helpers for size decode and alignment checking.
package mem_lsu_pkg;

  localparam int BYTE_W    = 8;
  localparam int HALF_W    = 16;
  localparam int WORD_W    = 32;
  localparam int NUM_LANES = WORD_W / BYTE_W;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RMW  = 1'b1
  } lsu_state_e;

  // Raw size 2'b11 is reserved and behaves as a word.
  function automatic size_e decode_size(input logic [1:0] raw);
    case (raw)
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input size_e sz, input logic [1:0] lo);
    case (sz)
      SZ_HALF: return lo[0];
      SZ_WORD: return lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// mem_lsu_if: pipeline request/response channel plus the word-only data
// memory port of the load/store unit.
//   slave  - the LSU side (takes requests, drives the memory port)
//   master - the pipeline + memory side (issues requests, returns dmem_rd)
interface mem_lsu_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_misalign;

  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_a;
  logic [DATA_W-1:0] dmem_wd;
  logic [DATA_W-1:0] dmem_rd;

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, dmem_rd,
    output req_ready, resp_valid, resp_rdata, resp_misalign, dmem_we, dmem_a, dmem_wd
  );

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, dmem_rd,
    input  req_ready, resp_valid, resp_rdata, resp_misalign, dmem_we, dmem_a, dmem_wd
  );
endinterface

// File: rtl/mem_lsu_lane_align.sv
// lsu_lane_align: combinational byte-lane logic for the LSU.
//   size, addr_lo, sgn - access size, low address bits, sign-extend select
//   rd                 - word read from memory
//   wdata              - store data (low byte/half used for sub-word stores)
//   ld_data            - extracted and extended load result
//   st_merge           - rd with the addressed lane(s) replaced by wdata
// A half only looks at addr_lo[1] and a word ignores addr_lo entirely, so
// unchecked misaligned accesses silently round down.
module lsu_lane_align
  import mem_lsu_pkg::*;
(
  input  size_e             size,
  input  logic [1:0]        addr_lo,
  input  logic              sgn,
  input  logic [WORD_W-1:0] rd,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] ld_data,
  output logic [WORD_W-1:0] st_merge
);

  logic [4:0]           sh;
  logic [WORD_W-1:0]    shifted;
  logic [WORD_W-1:0]    wrep;
  logic [NUM_LANES-1:0] be;

  always_comb begin
    sh   = '0;
    wrep = wdata;
    unique case (size)
      SZ_BYTE: begin
        sh   = {addr_lo, 3'b000};
        wrep = {NUM_LANES{wdata[BYTE_W-1:0]}};
      end
      SZ_HALF: begin
        sh   = {addr_lo[1], 4'b0000};
        wrep = {2{wdata[HALF_W-1:0]}};
      end
      default: ;
    endcase
    shifted = rd >> sh;
    unique case (size)
      SZ_BYTE: ld_data = {{(WORD_W-BYTE_W){sgn & shifted[BYTE_W-1]}}, shifted[BYTE_W-1:0]};
      SZ_HALF: ld_data = {{(WORD_W-HALF_W){sgn & shifted[HALF_W-1]}}, shifted[HALF_W-1:0]};
      default: ld_data = shifted;
    endcase
  end

  // Store data is replicated across lanes so each lane only needs its enable.
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    localparam logic [1:0] LANE = 2'(k);
    assign be[k] = (size == SZ_WORD)
                 || (size == SZ_HALF && addr_lo[1] == LANE[1])
                 || (size == SZ_BYTE && addr_lo == LANE);
    assign st_merge[k*BYTE_W +: BYTE_W] = be[k] ? wrep[k*BYTE_W +: BYTE_W]
                                                : rd[k*BYTE_W +: BYTE_W];
  end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit driving a word-only data memory
// (asynchronous read, write on rising clk).
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - mem_lsu_if.slave: req_* handshake in, resp_* out,
//                dmem_we/dmem_a/dmem_wd out, dmem_rd in
// Loads and word stores complete in one cycle. Byte/half stores read the
// word in IDLE, merge, and write it back from S_RMW while req_ready is low.
// Build option MEM_LSU_ALIGN_CHECK_EN: misaligned halves/words are accepted,
// touch no memory, and respond with resp_misalign=1 and zero data.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic      clk,
  input logic      rst_n,
  mem_lsu_if.slave bus
);

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:2] addr_q;
  logic [DATA_W-1:0] merged_q;
  logic              resp_valid_q, resp_d;
  logic [DATA_W-1:0] resp_rdata_q;
  logic              rmw_start;

  size_e             sz;
  logic              idle, accept, mis, sub_store;
  logic [DATA_W-1:0] ld_data, st_merge;

  assign sz        = decode_size(bus.req_size);
  assign idle      = (state_q == S_IDLE);
  assign accept    = bus.req_valid && idle;
  assign sub_store = bus.req_we && (sz != SZ_WORD);

`ifdef MEM_LSU_ALIGN_CHECK_EN
  assign mis = is_misaligned(sz, bus.req_addr[1:0]);
`else
  assign mis = 1'b0;
`endif

  lsu_lane_align u_align (
    .size     (sz),
    .addr_lo  (bus.req_addr[1:0]),
    .sgn      (bus.req_signed),
    .rd       (bus.dmem_rd),
    .wdata    (bus.req_wdata),
    .ld_data  (ld_data),
    .st_merge (st_merge)
  );

  always_comb begin
    state_d       = state_q;
    rmw_start     = 1'b0;
    resp_d        = 1'b0;
    bus.req_ready = 1'b1;
    bus.dmem_we   = 1'b0;
    bus.dmem_a    = {bus.req_addr[ADDR_W-1:2], 2'b00};
    bus.dmem_wd   = bus.req_wdata;
    unique case (state_q)
      S_IDLE: begin
        if (accept && !mis) begin
          if (bus.req_we && sz == SZ_WORD) begin
            bus.dmem_we = 1'b1;
          end else if (sub_store) begin
            rmw_start = 1'b1;
            state_d   = S_RMW;
          end
        end
        // Sub-word stores respond from S_RMW instead.
        resp_d = accept && !rmw_start;
      end
      S_RMW: begin
        bus.req_ready = 1'b0;
        bus.dmem_a    = {addr_q, 2'b00};
        bus.dmem_we   = 1'b1;
        bus.dmem_wd   = merged_q;
        resp_d        = 1'b1;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      merged_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= resp_d;
      resp_rdata_q <= (accept && !bus.req_we && !mis) ? ld_data : '0;
      if (rmw_start) begin
        addr_q   <= bus.req_addr[ADDR_W-1:2];
        merged_q <= st_merge;
      end
    end
  end

`ifdef MEM_LSU_ALIGN_CHECK_EN
  logic resp_mis_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) resp_mis_q <= 1'b0;
    else        resp_mis_q <= accept && mis;
  end
  assign bus.resp_misalign = resp_mis_q;
`else
  assign bus.resp_misalign = 1'b0;
`endif

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: self-checking bench for mem_lsu. A word memory hangs off the
// dmem port; expectations come from a byte-addressed reference memory
// updated with the architectural load/store rules.
module tb_mem_lsu;

`ifdef MEM_LSU_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_lsu_if bus ();

  mem_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] mem [64] = '{default: '0};
  assign bus.dmem_rd = mem[bus.dmem_a[7:2]];
  always @(posedge clk) if (bus.dmem_we) mem[bus.dmem_a[7:2]] <= bus.dmem_wd;

  logic [7:0] ref_mem [256];
  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  function automatic logic ref_mis(input logic [1:0] sz, input logic [31:0] a);
    return ALIGN_EN && ((sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00));
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic sg);
    int b;
    logic [7:0]  by;
    logic [15:0] h;
    b = int'(a[7:0]);
    case (sz)
      2'b00: begin
        by = ref_mem[b];
        return sg ? {{24{by[7]}}, by} : {24'h0, by};
      end
      2'b01: begin
        b = b & ~1;
        h = {ref_mem[b+1], ref_mem[b]};
        return sg ? {{16{h[15]}}, h} : {16'h0, h};
      end
      default: begin
        b = b & ~3;
        return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
      end
    endcase
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    int b;
    b = int'(a[7:0]);
    case (sz)
      2'b00: ref_mem[b] = wd[7:0];
      2'b01: begin b = b & ~1; ref_mem[b] = wd[7:0]; ref_mem[b+1] = wd[15:8]; end
      default: begin
        b = b & ~3;
        for (int i = 0; i < 4; i++) ref_mem[b+i] = wd[8*i +: 8];
      end
    endcase
  endtask

  // Drives one request (entered just after a negedge) and observes it until
  // its response. lat is -1 if the request was never accepted or answered.
  task automatic xact(input logic we, input logic [1:0] sz, input logic sg,
                      input logic [31:0] ad, input logic [31:0] wd,
                      output int lat, output logic [31:0] rdata, output logic mis,
                      output int we_cnt, output logic [31:0] wd_seen, output int rdy_lo);
    int w;
    lat = -1; rdata = 'x; mis = 'x; we_cnt = 0; wd_seen = '0; rdy_lo = 0; w = 0;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = sz;
    bus.req_signed = sg; bus.req_addr = ad; bus.req_wdata = wd;
    #1;
    while (!bus.req_ready && w < 10) begin @(negedge clk); #1; w++; end
    if (!bus.req_ready) begin bus.req_valid = 1'b0; return; end
    if (bus.dmem_we) begin we_cnt++; wd_seen = bus.dmem_wd; end
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
    for (int c = 1; c <= 4; c++) begin
      if (bus.dmem_we) begin we_cnt++; wd_seen = bus.dmem_wd; end
      if (!bus.req_ready) rdy_lo++;
      if (bus.resp_valid) begin
        lat = c; rdata = bus.resp_rdata; mis = bus.resp_misalign;
        break;
      end
      @(negedge clk); #1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b10;
    bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%b want=0", bus.resp_valid); end
    total++; if (bus.resp_rdata !== 32'h0) begin bad++; $display("FAIL reset_resp_rdata got=%h want=0", bus.resp_rdata); end
    total++; if (bus.resp_misalign !== 1'b0) begin bad++; $display("FAIL reset_misalign got=%b want=0", bus.resp_misalign); end
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b want=1", bus.req_ready); end
    total++; if (bus.dmem_we !== 1'b0) begin bad++; $display("FAIL reset_dmem_we got=%b want=0", bus.dmem_we); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load_ext;
    int lat, wc, rl; logic [31:0] rd, wds; logic m;
    xact(1'b1, 2'b10, 1'b0, 32'h10, 32'h8899AABB, lat, rd, m, wc, wds, rl);
    ref_store(32'h10, 2'b10, 32'h8899AABB);
    total++; if (lat !== 1 || wc !== 1 || wds !== 32'h8899AABB || rd !== 32'h0)
      begin bad++; $display("FAIL sw_0x10 lat=%0d we=%0d wd=%h rdata=%h want lat=1 we=1 wd=8899aabb rdata=0", lat, wc, wds, rd); end
    xact(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, lat, rd, m, wc, wds, rl);
    total++; if (lat !== 1 || rd !== 32'hFFFFFFAA)
      begin bad++; $display("FAIL lb_signed lat=%0d got=%h want lat=1 ffffffaa", lat, rd); end
    xact(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, lat, rd, m, wc, wds, rl);
    total++; if (lat !== 1 || rd !== 32'h000000AA)
      begin bad++; $display("FAIL lbu lat=%0d got=%h want lat=1 000000aa", lat, rd); end
    xact(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, lat, rd, m, wc, wds, rl);
    total++; if (rd !== 32'hFFFF8899) begin bad++; $display("FAIL lh_signed got=%h want ffff8899", rd); end
    xact(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, lat, rd, m, wc, wds, rl);
    total++; if (rd !== 32'h0000AABB) begin bad++; $display("FAIL lhu got=%h want 0000aabb", rd); end
  endtask

  task automatic test_rmw;
    int lat, wc, rl; logic [31:0] rd, wds; logic m;
    xact(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, lat, rd, m, wc, wds, rl);
    ref_store(32'h20, 2'b10, 32'h11223344);
    xact(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000BEEF, lat, rd, m, wc, wds, rl);
    ref_store(32'h22, 2'b01, 32'h0000BEEF);
    total++; if (lat !== 2) begin bad++; $display("FAIL sh_latency got=%0d want=2", lat); end
    total++; if (rl !== 1) begin bad++; $display("FAIL sh_ready_low got=%0d cycles want=1", rl); end
    total++; if (wc !== 1 || wds !== 32'hBEEF3344)
      begin bad++; $display("FAIL sh_write we=%0d wd=%h want we=1 wd=beef3344", wc, wds); end
    xact(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, lat, rd, m, wc, wds, rl);
    total++; if (rd !== 32'hBEEF3344) begin bad++; $display("FAIL lw_after_sh got=%h want beef3344", rd); end
  endtask

  task automatic test_back_to_back;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b10;
    bus.req_signed = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'hCAFEBABE;
    #1;
    total++; if (bus.dmem_we !== 1'b1 || bus.dmem_wd !== 32'hCAFEBABE || bus.dmem_a !== 32'h0)
      begin bad++; $display("FAIL b2b_sw_port we=%b wd=%h a=%h want 1 cafebabe 0", bus.dmem_we, bus.dmem_wd, bus.dmem_a); end
    @(posedge clk); @(negedge clk);
    ref_store(32'h0, 2'b10, 32'hCAFEBABE);
    bus.req_we = 1'b0; bus.req_wdata = 32'h0;
    #1;
    total++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'h0 || bus.req_ready !== 1'b1)
      begin bad++; $display("FAIL b2b_sw_resp valid=%b rdata=%h ready=%b want 1 0 1", bus.resp_valid, bus.resp_rdata, bus.req_ready); end
    @(posedge clk); @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
    total++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'hCAFEBABE)
      begin bad++; $display("FAIL b2b_lw_resp valid=%b rdata=%h want 1 cafebabe", bus.resp_valid, bus.resp_rdata); end
    @(negedge clk); #1;
    total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL b2b_idle_valid got=%b want=0", bus.resp_valid); end
  endtask

  task automatic test_stall;
    logic [31:0] exp_w;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b00;
    bus.req_signed = 1'b0; bus.req_addr = 32'h33; bus.req_wdata = 32'h0000005A;
    #1;
    total++; if (bus.dmem_we !== 1'b0) begin bad++; $display("FAIL sb_read_phase_we got=%b want=0", bus.dmem_we); end
    ref_store(32'h33, 2'b00, 32'h5A);
    exp_w = ref_load(32'h30, 2'b10, 1'b0);
    @(posedge clk); @(negedge clk);
    bus.req_we = 1'b0; bus.req_size = 2'b10; bus.req_addr = 32'h30; bus.req_wdata = 32'h0;
    #1;
    total++; if (bus.req_ready !== 1'b0 || bus.dmem_we !== 1'b1 || bus.dmem_wd !== exp_w || bus.dmem_a !== 32'h30)
      begin bad++; $display("FAIL sb_rmw ready=%b we=%b wd=%h a=%h want 0 1 %h 30", bus.req_ready, bus.dmem_we, bus.dmem_wd, bus.dmem_a, exp_w); end
    @(posedge clk); @(negedge clk); #1;
    total++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b1)
      begin bad++; $display("FAIL sb_resp ready=%b valid=%b want 1 1", bus.req_ready, bus.resp_valid); end
    @(posedge clk); @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
    total++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata[31:24] !== 8'h5A || bus.resp_rdata !== exp_w)
      begin bad++; $display("FAIL stalled_lw valid=%b rdata=%h want 1 %h", bus.resp_valid, bus.resp_rdata, exp_w); end
    @(negedge clk);
  endtask

  task automatic test_misalign;
    int lat, wc, rl; logic [31:0] rd, wds; logic m;
    xact(1'b1, 2'b10, 1'b0, 32'h06, 32'h12345678, lat, rd, m, wc, wds, rl);
`ifdef MEM_LSU_ALIGN_CHECK_EN
    total++; if (lat !== 1 || wc !== 0 || m !== 1'b1 || rd !== 32'h0)
      begin bad++; $display("FAIL misalign_sw lat=%0d we=%0d mis=%b rdata=%h want 1 0 1 0", lat, wc, m, rd); end
`else
    ref_store(32'h06, 2'b10, 32'h12345678);
    total++; if (lat !== 1 || wc !== 1 || m !== 1'b0)
      begin bad++; $display("FAIL unaligned_sw lat=%0d we=%0d mis=%b want 1 1 0", lat, wc, m); end
`endif
    xact(1'b0, 2'b10, 1'b0, 32'h04, 32'h0, lat, rd, m, wc, wds, rl);
    total++; if (rd !== ref_load(32'h04, 2'b10, 1'b0))
      begin bad++; $display("FAIL word_0x04 got=%h want %h", rd, ref_load(32'h04, 2'b10, 1'b0)); end
  endtask

  task automatic test_reset_rmw;
    int lat, wc, rl, seen; logic [31:0] rd, wds; logic m;
    xact(1'b1, 2'b10, 1'b0, 32'h40, 32'hA1B2C3D4, lat, rd, m, wc, wds, rl);
    ref_store(32'h40, 2'b10, 32'hA1B2C3D4);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b00;
    bus.req_addr = 32'h41; bus.req_wdata = 32'h77;
    @(posedge clk); @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
    total++; if (bus.dmem_we !== 1'b1) begin bad++; $display("FAIL rst_rmw_entry we=%b want=1", bus.dmem_we); end
    rst_n = 1'b0;
    #1;
    total++; if (bus.dmem_we !== 1'b0) begin bad++; $display("FAIL rst_rmw_abort we=%b want=0", bus.dmem_we); end
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 3; i++) begin #1; if (bus.resp_valid) seen++; @(negedge clk); end
    total++; if (seen !== 0) begin bad++; $display("FAIL rst_rmw_no_resp pulses=%0d want=0", seen); end
    xact(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, lat, rd, m, wc, wds, rl);
    total++; if (rd !== 32'hA1B2C3D4) begin bad++; $display("FAIL rst_rmw_mem got=%h want a1b2c3d4", rd); end
  endtask

  task automatic test_random;
    int lat, wc, rl, exp_lat, exp_wc; logic [31:0] rd, wds, ad, wd, exp_rd; logic m, we, sg, em;
    logic [1:0] sz;
    for (int n = 0; n < 60; n++) begin
      we = 1'($urandom_range(0, 1)); sz = 2'($urandom_range(0, 3));
      sg = 1'($urandom_range(0, 1)); ad = 32'($urandom_range(0, 255)); wd = $urandom;
      em = ref_mis(sz, ad);
      exp_lat = (we && !sz[1] && !em) ? 2 : 1;
      exp_wc  = (we && !em) ? 1 : 0;
      exp_rd  = (we || em) ? 32'h0 : ref_load(ad, sz, sg);
      xact(we, sz, sg, ad, wd, lat, rd, m, wc, wds, rl);
      if (we && !em) ref_store(ad, sz, wd);
      total++; if (lat !== exp_lat || wc !== exp_wc || rd !== exp_rd || m !== em)
        begin bad++; $display("FAIL rand%0d we=%b sz=%0d a=%h lat=%0d/%0d wr=%0d/%0d rdata=%h/%h mis=%b/%b",
          n, we, sz, ad, lat, exp_lat, wc, exp_wc, rd, exp_rd, m, em); end
    end
    for (int w = 0; w < 64; w++) begin
      ad = 32'(w * 4);
      xact(1'b0, 2'b10, 1'b0, ad, 32'h0, lat, rd, m, wc, wds, rl);
      total++; if (rd !== ref_load(ad, 2'b10, 1'b0))
        begin bad++; $display("FAIL sweep a=%h got=%h want %h", ad, rd, ref_load(ad, 2'b10, 1'b0)); end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    @(negedge clk);
    test_reset;
    test_load_ext;
    test_rmw;
    test_back_to_back;
    test_stall;
    test_misalign;
    test_reset_rmw;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
